life_engine: RTL
================

Name: life_engine

Overview:
- Sequential Conway's Life engine. Holds the grid state in registers and advances one generation per enabled clock under a load/step/run control interface.
- Parametrised successor to the combinational per-cell grid. Adds selectable toroidal wrap-around, a generation counter, and automatic halt on stable, extinct or generation-limit conditions.
- Sits between the pattern loader and the display/readout logic.

Parameters:
- GRID_WIDTH, 8, cells per row; >=1, and >=3 when WRAP=1 (elaboration error otherwise).
- GRID_HEIGHT, 8, rows; >=1, and >=3 when WRAP=1.
- WRAP, 0, 0 = cells outside the grid are dead; 1 = toroidal edges (indices mod width/height).
- GEN_WIDTH, 16, width of the generation counter and limit.

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- RST_N  in  1  synchronous, active-low reset.
- LOAD  in  1  load LOAD_STATE; highest priority after reset.
- LOAD_STATE  in  GRID_WIDTH*GRID_HEIGHT  pattern to load; cell (x,y) is bit GRID_WIDTH*y+x.
- STEP  in  1  request one generation while IDLE.
- RUN  in  1  free-run level.
- MAX_GEN  in  GEN_WIDTH  generation limit; 0 = unlimited.
- STATE  out  GRID_WIDTH*GRID_HEIGHT  current grid, same bit mapping.
- GENERATION  out  GEN_WIDTH  advances since last load/reset.
- STEP_DONE  out  1  one-cycle pulse the cycle after each advance.
- STABLE  out  1  last advance produced next==current.
- EXTINCT  out  1  combinational (STATE==0).
- HALTED  out  1  FSM is in HALTED.

Behaviour:
- Reset (RST_N=0 at edge) sets STATE=0, GENERATION=0, STEP_DONE=0, STABLE=0, FSM=IDLE. EXTINCT therefore reads 1. Reset overrides everything, including mid-run.
- Next-state function per cell: rule B3/S23 over 8 neighbours. Neighbour order is N(x,y-1), NE, E, SE, S, SW, W, NW.
  - WRAP=0: out-of-range neighbours read 0.
  - WRAP=1: wrap modulo GRID_WIDTH/GRID_HEIGHT.
- An "advance" registers the next state:
  - STATE<=next, GENERATION<=GENERATION+1, STEP_DONE=1 in the following cycle.
  - Latency is 1 clock from the accepting edge to the updated STATE.
- LOAD=1, from any FSM state: STATE<=LOAD_STATE, GENERATION<=0, STABLE<=0, STEP_DONE<=0, FSM<=IDLE. STEP and RUN are ignored that cycle.
- FSM states IDLE, RUNNING, HALTED:
  - IDLE, RUN=1: go to RUNNING; no advance this cycle.
  - IDLE, RUN=0, STEP=1: one advance; stay IDLE unless a halt condition fires.
  - RUNNING, RUN=1: one advance every cycle. STEP is ignored.
  - RUNNING, RUN=0: go to IDLE; no advance.
  - HALTED: no advances; STEP and RUN are ignored. Exit only via LOAD or reset.
- Halt check is evaluated on every advance, against the values being written. Any of the following moves the FSM to HALTED on the same edge:
  - next==current: sets STABLE<=1.
  - next==0.
  - MAX_GEN!=0 and GENERATION+1==MAX_GEN.
  - GENERATION+1 == all-ones (counter saturation; never wraps).
- STABLE holds until the next LOAD or reset.
- Advancing an all-zero grid gives next==current==0: STABLE=1 and EXTINCT=1, then HALTED.
- MAX_GEN is sampled every advance. Lowering MAX_GEN below GENERATION+1 does not halt; the run continues until another condition fires.

Test Plan:
- Reset during RUNNING at generation 5 -> next cycle STATE=0, GENERATION=0, HALTED=0, EXTINCT=1, STEP_DONE=0.
- 8x8, WRAP=0: load blinker at (3,2),(3,3),(3,4), pulse STEP -> STATE holds (2,3),(3,3),(4,3), GENERATION=1, STEP_DONE pulses once. A second STEP restores the original, GENERATION=2.
- 8x8, WRAP=1: load glider (1,0),(2,1),(0,2),(1,2),(2,2), RUN=1, MAX_GEN=32 -> HALTED after exactly 32 advances with STATE==loaded pattern and STABLE=0.
- 8x8, WRAP=0: same glider, RUN=1, MAX_GEN=0 -> glider settles into a 2x2 block at the SE corner. STABLE=1, HALTED=1, and GENERATION equals the first generation whose result equals its predecessor.
- Load a single cell at (4,4), STEP -> STATE=0, EXTINCT=1, HALTED=1, GENERATION=1. Further STEP/RUN do not change GENERATION.
- RUNNING at generation 3 with LOAD=1 and STEP=1 on the same edge -> STATE=LOAD_STATE, GENERATION=0, FSM=IDLE, no STEP_DONE. Then raise RUN while MAX_GEN=2 -> halts at GENERATION=2.

Source files
------------

// File: rtl/life_engine.sv
// rtl/life_engine.sv - sequential Conway's Life engine with load/step/run control
// Registered grid, B3/S23 next-state logic, generation counter and auto-halt.
module life_engine #(
  parameter int GRID_WIDTH  = 8,
  parameter int GRID_HEIGHT = 8,
  parameter int WRAP        = 0,
  parameter int GEN_WIDTH   = 16
) (
  input  logic                            CLK,
  input  logic                            RST_N,
  input  logic                            LOAD,
  input  logic [GRID_WIDTH*GRID_HEIGHT-1:0] LOAD_STATE,
  input  logic                            STEP,
  input  logic                            RUN,
  input  logic [GEN_WIDTH-1:0]            MAX_GEN,
  output logic [GRID_WIDTH*GRID_HEIGHT-1:0] STATE,
  output logic [GEN_WIDTH-1:0]            GENERATION,
  output logic                            STEP_DONE,
  output logic                            STABLE,
  output logic                            EXTINCT,
  output logic                            HALTED
);

  localparam int N = GRID_WIDTH * GRID_HEIGHT;

  if (GRID_WIDTH < 1 || GRID_HEIGHT < 1 ||
      (WRAP != 0 && (GRID_WIDTH < 3 || GRID_HEIGHT < 3))) begin : g_bad_params
    $error("life_engine: grid too small for the selected edge mode");
  end

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUNNING = 2'd1,
    S_HALTED  = 2'd2
  } fsm_t;

  fsm_t           fsm_q, fsm_d;
  logic [N-1:0]   next_grid;
  logic           advance;
  logic           halt_cond;
  logic           same_next;
  logic [GEN_WIDTH-1:0] gen_inc;

  // Neighbour k follows N, NE, E, SE, S, SW, W, NW; off-grid cells are tied low.
  for (genvar y = 0; y < GRID_HEIGHT; y++) begin : g_row
    for (genvar x = 0; x < GRID_WIDTH; x++) begin : g_col
      logic [7:0] nb;
      logic [3:0] cnt;
      for (genvar k = 0; k < 8; k++) begin : g_nb
        localparam int DX = (k == 1 || k == 2 || k == 3) ? 1 :
                            (k == 5 || k == 6 || k == 7) ? -1 : 0;
        localparam int DY = (k == 0 || k == 1 || k == 7) ? -1 :
                            (k == 3 || k == 4 || k == 5) ? 1 : 0;
        localparam int NX = (WRAP != 0) ? (x + DX + GRID_WIDTH) % GRID_WIDTH : x + DX;
        localparam int NY = (WRAP != 0) ? (y + DY + GRID_HEIGHT) % GRID_HEIGHT : y + DY;
        if (NX >= 0 && NX < GRID_WIDTH && NY >= 0 && NY < GRID_HEIGHT) begin : g_in
          assign nb[k] = STATE[GRID_WIDTH*NY + NX];
        end else begin : g_out
          assign nb[k] = 1'b0;
        end
      end
      always_comb begin
        cnt = 4'd0;
        for (int k = 0; k < 8; k++) cnt = cnt + {3'b000, nb[k]};
      end
      assign next_grid[GRID_WIDTH*y + x] =
        (cnt == 4'd3) | (STATE[GRID_WIDTH*y + x] & (cnt == 4'd2));
    end
  end

  assign gen_inc   = GENERATION + {{(GEN_WIDTH-1){1'b0}}, 1'b1};
  assign same_next = (next_grid == STATE);
  assign halt_cond = same_next || (next_grid == '0) ||
                     ((MAX_GEN != '0) && (gen_inc == MAX_GEN)) || (&gen_inc);

  always_comb begin
    fsm_d   = fsm_q;
    advance = 1'b0;
    case (fsm_q)
      S_IDLE: begin
        if (RUN)       fsm_d   = S_RUNNING;
        else if (STEP) advance = 1'b1;
      end
      S_RUNNING: begin
        if (RUN) advance = 1'b1;
        else     fsm_d   = S_IDLE;
      end
      default: fsm_d = S_HALTED;
    endcase
    if (advance && halt_cond) fsm_d = S_HALTED;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      fsm_q      <= S_IDLE;
      STATE      <= '0;
      GENERATION <= '0;
      STEP_DONE  <= 1'b0;
      STABLE     <= 1'b0;
    end else if (LOAD) begin
      fsm_q      <= S_IDLE;
      STATE      <= LOAD_STATE;
      GENERATION <= '0;
      STEP_DONE  <= 1'b0;
      STABLE     <= 1'b0;
    end else begin
      fsm_q     <= fsm_d;
      STEP_DONE <= advance;
      if (advance) begin
        STATE      <= next_grid;
        GENERATION <= gen_inc;
        if (same_next) STABLE <= 1'b1;
      end
    end
  end

  assign EXTINCT = (STATE == '0);
  assign HALTED  = (fsm_q == S_HALTED);

endmodule
